sample_output_register: RTL and testbench

- Consumer end of the generator-to-output-register protocol: accepts one 12-bit sample per clock from any signal generator (noise, LFM, etc.) framed by SIGN_START_CALC / SIGN_STOP_CALC.
- Buffers samples in a FIFO and streams them to the DAC interface with a valid/ready handshake.
- Drives OUT_REG_READY to gate the next generator start.
- Sits between the generator bank and the DAC driver.

---
 rtl/sample_output_register_pkg.sv | 28 ++
 rtl/sample_output_register_if.sv | 27 ++
 rtl/sample_output_register_sync_fifo.sv | 52 +++++
 rtl/sample_output_register.sv | 76 +++++++
 tb/tb_sample_output_register.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/sample_output_register_pkg.sv
// Shared definitions for the generator-to-output-register path: sample format,
// FSM encoding and the signal-type codes used by the generator bank.
package sample_output_register_pkg;

   localparam int DATA_W     = 12;
   localparam int FIFO_DEPTH = 16;
   localparam int ADDR_W     = $clog2(FIFO_DEPTH);

   localparam logic [DATA_W-1:0] IDLE_LEVEL = 12'd2048;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CAPTURE,
      ST_DRAIN
   } state_t;

   typedef enum logic [2:0] {
      SIG_NONE,
      SIG_NOISE,
      SIG_LFM,
      SIG_TONE
   } sig_type_t;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/sample_output_register_if.sv
// Generator-side and DAC-side signals of the output register; master is the
// generator/DAC environment, slave is the output register itself.
interface sample_output_register_if;
   import sample_output_register_pkg::*;

   logic              SIGN_START_CALC;
   logic              SIGN_STOP_CALC;
   logic [DATA_W-1:0] SAMPLE_IN;
   logic              DAC_READY;
   logic              OUT_REG_READY;
   logic [DATA_W-1:0] DAC_DATA;
   logic              DAC_VALID;
   logic [ADDR_W:0]   FIFO_LEVEL;
   logic              OVERFLOW;
   logic [31:0]       SAMPLE_COUNT;

   modport master (
      output SIGN_START_CALC, SIGN_STOP_CALC, SAMPLE_IN, DAC_READY,
      input  OUT_REG_READY, DAC_DATA, DAC_VALID, FIFO_LEVEL, OVERFLOW, SAMPLE_COUNT
   );

   modport slave (
      input  SIGN_START_CALC, SIGN_STOP_CALC, SAMPLE_IN, DAC_READY,
      output OUT_REG_READY, DAC_DATA, DAC_VALID, FIFO_LEVEL, OVERFLOW, SAMPLE_COUNT
   );

endinterface

// File: rtl/sample_output_register_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only when a
// pop frees the slot in the same cycle.
module sync_fifo #(
   parameter int DW = 12,
   parameter int AW = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [AW:0]   level_o
);
   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wptr_q, rptr_q;
   logic [AW:0]   level_q;
   logic          do_push, do_pop;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == (AW+1)'(DEPTH));
   assign level_o = level_q;
   assign rdata_o = mem_q[rptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         level_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + 1'b1;
            2'b01:   level_q <= level_q - 1'b1;
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/sample_output_register.sv
// Packet capture FSM in front of the DAC FIFO: frames generator samples between
// start/stop strobes and signals when the next generator may start.
module sample_output_register
   import sample_output_register_pkg::*;
(
   input  logic                     CLK,
   input  logic                     RESET,
   sample_output_register_if.slave  bus
);
   state_t            state_q;
   logic              rdy_q;
   logic              ovf_q;
   logic [31:0]       cnt_q;

   logic              push, pop, full, empty, accept, drop, drained;
   logic [ADDR_W:0]   level;
   logic [DATA_W-1:0] head;

   assign push    = (state_q == ST_CAPTURE);
   assign pop     = bus.DAC_READY && !empty;
   assign accept  = push && (!full || pop);
   assign drop    = push && full && !pop;
   // A pop of the final entry counts as empty so IDLE is reached on that edge.
   assign drained = empty || ((level == (ADDR_W+1)'(1)) && pop);

   sync_fifo #(.DW(DATA_W), .AW(ADDR_W)) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RESET),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i (bus.SAMPLE_IN),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level)
   );

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         rdy_q   <= 1'b1;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (bus.SIGN_START_CALC) begin
               state_q <= ST_CAPTURE;
               rdy_q   <= 1'b0;
               ovf_q   <= 1'b0;
               cnt_q   <= '0;
            end
            ST_CAPTURE: begin
               if (accept) cnt_q <= sat_inc32(cnt_q);
               if (drop)   ovf_q <= 1'b1;
               if (bus.SIGN_STOP_CALC) state_q <= ST_DRAIN;
            end
            ST_DRAIN: if (drained) begin
               state_q <= ST_IDLE;
               rdy_q   <= 1'b1;
            end
            default: begin
               state_q <= ST_IDLE;
               rdy_q   <= 1'b1;
            end
         endcase
      end
   end

   assign bus.OUT_REG_READY = rdy_q;
   assign bus.DAC_VALID     = !empty;
   assign bus.DAC_DATA      = empty ? IDLE_LEVEL : head;
   assign bus.FIFO_LEVEL    = level;
   assign bus.OVERFLOW      = ovf_q;
   assign bus.SAMPLE_COUNT  = cnt_q;

endmodule

// File: tb/tb_sample_output_register.sv
// Scoreboard bench: stimulus queues expected DAC samples, a negedge monitor pops
// and compares on every DAC handshake.
module tb_sample_output_register;
   import sample_output_register_pkg::*;

   logic CLK = 1'b0;
   logic RESET;
   sample_output_register_if bus();

   sample_output_register dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus.slave)
   );

   always #5 CLK = ~CLK;

   int checks   = 0;
   int failures = 0;
   int exp_q[$];
   int maxlvl   = 0;
   int cyc;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Scoreboard monitor plus the idle/empty invariant.
   always @(negedge CLK) begin
      if (RESET === 1'b0) begin
         if (int'(bus.FIFO_LEVEL) > maxlvl) maxlvl = int'(bus.FIFO_LEVEL);
         if (bus.DAC_VALID && bus.DAC_READY) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL dac_unexpected: got %0d expected no sample", bus.DAC_DATA);
            end else begin
               chk("dac_data", bus.DAC_DATA, exp_q.pop_front());
            end
         end
         if (bus.OUT_REG_READY) chk("ready_implies_empty", bus.FIFO_LEVEL, 0);
      end
   end

   // START in cycle 0, samples base.. in cycles 1..n with STOP on the last;
   // DAC_READY rises at sample index rdy_from and stays high after STOP.
   task automatic send(input int base, input int n, input int rdy_from, input int n_exp);
      for (int i = 0; i < n_exp; i++) exp_q.push_back(base + i);
      bus.SIGN_START_CALC = 1'b1;
      bus.DAC_READY       = (rdy_from <= 1);
      step();
      bus.SIGN_START_CALC = 1'b0;
      for (int i = 1; i <= n; i++) begin
         bus.SAMPLE_IN      = 12'(base + i - 1);
         bus.SIGN_STOP_CALC = (i == n);
         bus.DAC_READY      = (i >= rdy_from);
         step();
      end
      bus.SIGN_STOP_CALC = 1'b0;
      bus.DAC_READY      = 1'b1;
   endtask

   task automatic wait_idle(input int budget, output int n);
      n = 0;
      while (n < budget) begin
         @(negedge CLK);
         n++;
         if (bus.OUT_REG_READY) break;
      end
      chk("idle_reached", bus.OUT_REG_READY, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET               = 1'b1;
      bus.SIGN_START_CALC = 1'b0;
      bus.SIGN_STOP_CALC  = 1'b0;
      bus.SAMPLE_IN       = '0;
      bus.DAC_READY       = 1'b0;
      repeat (3) step();
      RESET = 1'b0;
      @(negedge CLK);
      chk("rst_out_reg_ready", bus.OUT_REG_READY, 1);
      chk("rst_dac_valid", bus.DAC_VALID, 0);
      chk("rst_dac_data", bus.DAC_DATA, 2048);
      chk("rst_fifo_level", bus.FIFO_LEVEL, 0);
      chk("rst_overflow", bus.OVERFLOW, 0);
      chk("rst_sample_count", bus.SAMPLE_COUNT, 0);

      // 10 samples streamed straight through
      maxlvl = 0;
      send(100, 10, 1, 10);
      @(negedge CLK);
      chk("t2_last_on_dac", bus.DAC_DATA, 109);
      chk("t2_level_last", bus.FIFO_LEVEL, 1);
      chk("t2_busy", bus.OUT_REG_READY, 0);
      wait_idle(50, cyc);
      chk("t2_idle_on_pop_edge", cyc, 1);
      chk("t2_count", bus.SAMPLE_COUNT, 10);
      chk("t2_overflow", bus.OVERFLOW, 0);
      chk("t2_max_level", maxlvl, 1);
      chk("t2_idle_dac_data", bus.DAC_DATA, 2048);

      // same packet buffered, drained after STOP
      send(100, 10, 11, 10);
      @(negedge CLK);
      chk("t3_level", bus.FIFO_LEVEL, 10);
      chk("t3_busy", bus.OUT_REG_READY, 0);
      chk("t3_count", bus.SAMPLE_COUNT, 10);
      wait_idle(50, cyc);
      chk("t3_drain_cycles", cyc, 10);

      // overflow: 20 samples into 16 slots
      send(0, 20, 21, 16);
      @(negedge CLK);
      chk("t4_level_full", bus.FIFO_LEVEL, 16);
      chk("t4_overflow", bus.OVERFLOW, 1);
      chk("t4_count", bus.SAMPLE_COUNT, 16);
      chk("t4_head", bus.DAC_DATA, 0);
      wait_idle(50, cyc);
      chk("t4_drain_cycles", cyc, 16);
      chk("t4_overflow_sticky", bus.OVERFLOW, 1);

      // full FIFO with push+pop in the same cycle
      send(200, 20, 17, 20);
      @(negedge CLK);
      chk("t5_level_full", bus.FIFO_LEVEL, 16);
      chk("t5_overflow_cleared", bus.OVERFLOW, 0);
      chk("t5_count", bus.SAMPLE_COUNT, 20);
      wait_idle(50, cyc);
      chk("t5_drain_cycles", cyc, 16);

      // reset in the middle of CAPTURE
      bus.SIGN_START_CALC = 1'b1;
      bus.DAC_READY       = 1'b0;
      step();
      bus.SIGN_START_CALC = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.SAMPLE_IN = 12'(500 + i);
         step();
      end
      RESET         = 1'b1;
      bus.SAMPLE_IN = 12'd505;
      step();
      RESET = 1'b0;
      @(negedge CLK);
      chk("t6_rst_level", bus.FIFO_LEVEL, 0);
      chk("t6_rst_ready", bus.OUT_REG_READY, 1);
      chk("t6_rst_valid", bus.DAC_VALID, 0);
      bus.DAC_READY = 1'b1;
      bus.SAMPLE_IN = 12'd777;
      step();
      @(negedge CLK);
      chk("t6_idle_ignores_sample", bus.FIFO_LEVEL, 0);

      // second START inside CAPTURE is ignored
      exp_q.push_back(300);
      exp_q.push_back(301);
      exp_q.push_back(302);
      bus.SIGN_START_CALC = 1'b1;
      step();
      bus.SIGN_START_CALC = 1'b0;
      bus.SAMPLE_IN       = 12'd300;
      step();
      bus.SAMPLE_IN       = 12'd301;
      bus.SIGN_START_CALC = 1'b1;
      step();
      bus.SIGN_START_CALC = 1'b0;
      bus.SAMPLE_IN       = 12'd302;
      bus.SIGN_STOP_CALC  = 1'b1;
      step();
      bus.SIGN_STOP_CALC  = 1'b0;
      @(negedge CLK);
      chk("t6_count_restart_ignored", bus.SAMPLE_COUNT, 3);
      wait_idle(50, cyc);

      // STOP in IDLE does nothing
      bus.SIGN_STOP_CALC = 1'b1;
      bus.SAMPLE_IN      = 12'd999;
      step();
      bus.SIGN_STOP_CALC = 1'b0;
      @(negedge CLK);
      chk("t6_stop_idle_ready", bus.OUT_REG_READY, 1);
      chk("t6_stop_idle_level", bus.FIFO_LEVEL, 0);
      chk("t6_stop_idle_count", bus.SAMPLE_COUNT, 3);
      step();
      @(negedge CLK);
      chk("t6_stop_idle_ready_hold", bus.OUT_REG_READY, 1);

      chk("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
